core_message_arbiter: RTL
=========================

// Module: core_message_arbiter
// PURPOSE
//  Serialises core-originated messages from core 0 and core 1 onto the single coreMessage* request port
//  of the processor message handler (PMH). Latches the granted core's message fields and drives
//  enabled/coreMessageSource. Holds the request until PMH asserts finished, then enforces a recovery gap.
//  Uses round-robin priority so neither core starves the other. Sits between both cores and the PMH.
// PARAMETERS
//  addrBits       16   width of channel / numWords fields
//  dataBits       16   width of message payload
//  cooldownCycles 2    idle cycles after finished before next grant (PMH internal-state reset); valid range 1..15
//  timeoutCycles  255  watchdog limit in cycles (used only with CORE_MSG_ARB_WATCHDOG_EN)
// PORTS
//  clk                        in   1         system clock, rising edge
//  reset                      in   1         asynchronous, active-low reset
//  coreNRequest (N=0,1)       in   1         core N has a message pending; fields stable while high
//  coreNMessage               in   4         message code
//  coreNChannel               in   addrBits  channel id
//  coreNData                  in   dataBits  message payload
//  coreNNumWords              in   addrBits  word count (start process)
//  coreNJumpDestination       in   9         jump target
//  coreNInAlt                 in   1         message issued inside an alt
//  coreNGrant                 out  1         1-cycle pulse: fields latched, core must drop request
//  coreNDone                  out  1         1-cycle pulse: PMH finished this core's message
//  enabled                    out  1         request to PMH
//  finished                   in   1         PMH completion
//  coreMessage                out  4         latched code to PMH
//  coreMessageChannel         out  addrBits  latched channel id
//  coreMessageMessage         out  dataBits  latched payload
//  coreMessageNumWords        out  addrBits  latched word count
//  coreMessageJumpDestination out  9         latched jump target
//  coreHadMessageInAlt        out  1         latched alt flag
//  coreMessageSource          out  1         0 = core 0, 1 = core 1
//  busy                       out  1         state != IDLE
//  watchdogFired              out  1         sticky timeout flag (0 when feature compiled out)
// BEHAVIOUR
//  - Reset (async, reset==0): all outputs 0, state IDLE, lastServed=1 (core 0 wins first tie).
//  - Reset asserted mid-operation drops enabled immediately. Any in-flight message is discarded with no done pulse.
//  - FSM states: IDLE, WAIT, COOLDOWN. All outputs are registered.
//  - IDLE, on a clock edge with any request high:
//    - Select a core: the sole requester, or on a tie the core != lastServed.
//    - Latch all fields; coreMessageSource = selected core.
//    - enabled <= 1 and coreNGrant <= 1 for one cycle; lastServed <= N; go to WAIT.
//    - Latency: request sampled at edge k, enabled and grant high after edge k.
//  - WAIT: enabled and latched fields held stable. Requests are ignored, including a re-request from the granted core.
//    - finished sampled 1: enabled <= 0, coreNDone <= 1 for one cycle, counter <= cooldownCycles, go to COOLDOWN.
//  - COOLDOWN: counter decrements each cycle; at 1 go to IDLE.
//    - Earliest next grant is cooldownCycles+1 edges after finished was sampled.
//  - finished high while in IDLE or COOLDOWN is ignored.
//  - The latched fields keep their last values after done; only enabled frames validity.
//  - A request still high on the cycle after its grant is treated as a new message once back in IDLE.
//    Cores must drop request on grant.
// CONFIGURATION
//  CORE_MSG_ARB_WATCHDOG_EN defined:
//    - An 8+ bit counter runs in WAIT. When it reaches timeoutCycles without finished:
//      enabled <= 0, watchdogFired <= 1 (sticky until reset), no done pulse, go to COOLDOWN.
//  CORE_MSG_ARB_WATCHDOG_EN undefined:
//    - No counter; WAIT waits indefinitely; watchdogFired tied 0.
// TESTING
//  - Reset: after release, all outputs 0 and busy=0.
//  - Single request: core0Request, code START_PROCESS, numWords 3.
//    - Expect enabled=1, coreMessageSource=0, coreMessageNumWords=3 and core0Grant pulse on the same edge.
//    - Drive finished 1 cycle later; expect core0Done pulse.
//  - Tie: both cores request at reset exit.
//    - Expect core 0 granted first; after its finished plus 2 cooldown cycles, core 1 granted (channel 2, data 42).
//  - Fairness: core 0 re-requests immediately after each done while core 1 is held high.
//    - Expect grants to alternate 0,1,0,1 over 4 messages.
//  - Stall: delay finished by 10 cycles.
//    - Expect enabled and fields stable throughout; core 1 request ignored until COOLDOWN ends.
//  - Mid-op reset: pull reset low while in WAIT. Expect enabled=0 asynchronously and no done pulse.
//    - With CORE_MSG_ARB_WATCHDOG_EN and timeoutCycles=4, withhold finished; expect watchdogFired=1 and enabled=0.

Source files
------------

// File: rtl/core_message_arbiter_if.sv
// rtl/core_message_arbiter_if.sv - Core 0/1 message request and PMH request/finished bundle.
interface core_message_arbiter_if #(
   parameter int addrBits = 16,
   parameter int dataBits = 16
);
   logic                core0Request;
   logic [3:0]          core0Message;
   logic [addrBits-1:0] core0Channel;
   logic [dataBits-1:0] core0Data;
   logic [addrBits-1:0] core0NumWords;
   logic [8:0]          core0JumpDestination;
   logic                core0InAlt;
   logic                core0Grant;
   logic                core0Done;

   logic                core1Request;
   logic [3:0]          core1Message;
   logic [addrBits-1:0] core1Channel;
   logic [dataBits-1:0] core1Data;
   logic [addrBits-1:0] core1NumWords;
   logic [8:0]          core1JumpDestination;
   logic                core1InAlt;
   logic                core1Grant;
   logic                core1Done;

   logic                enabled;
   logic                finished;
   logic [3:0]          coreMessage;
   logic [addrBits-1:0] coreMessageChannel;
   logic [dataBits-1:0] coreMessageMessage;
   logic [addrBits-1:0] coreMessageNumWords;
   logic [8:0]          coreMessageJumpDestination;
   logic                coreHadMessageInAlt;
   logic                coreMessageSource;
   logic                busy;
   logic                watchdogFired;

   modport slave (
      input  core0Request, core0Message, core0Channel, core0Data, core0NumWords,
             core0JumpDestination, core0InAlt,
      input  core1Request, core1Message, core1Channel, core1Data, core1NumWords,
             core1JumpDestination, core1InAlt,
      input  finished,
      output core0Grant, core0Done, core1Grant, core1Done,
      output enabled, coreMessage, coreMessageChannel, coreMessageMessage,
             coreMessageNumWords, coreMessageJumpDestination, coreHadMessageInAlt,
             coreMessageSource, busy, watchdogFired
   );

   modport master (
      output core0Request, core0Message, core0Channel, core0Data, core0NumWords,
             core0JumpDestination, core0InAlt,
      output core1Request, core1Message, core1Channel, core1Data, core1NumWords,
             core1JumpDestination, core1InAlt,
      output finished,
      input  core0Grant, core0Done, core1Grant, core1Done,
      input  enabled, coreMessage, coreMessageChannel, coreMessageMessage,
             coreMessageNumWords, coreMessageJumpDestination, coreHadMessageInAlt,
             coreMessageSource, busy, watchdogFired
   );
endinterface

// File: rtl/core_message_arbiter.sv
// rtl/core_message_arbiter.sv - Round-robin serialiser of core 0/1 messages onto the PMH request port.
// Optional watchdog on the WAIT state: define CORE_MSG_ARB_WATCHDOG_EN.
module core_message_arbiter #(
   parameter int addrBits       = 16,
   parameter int dataBits       = 16,
   parameter int cooldownCycles = 2,
   parameter int timeoutCycles  = 255
) (
   input  logic                  clk,
   input  logic                  reset,
   core_message_arbiter_if.slave bus
);
   // One down-counter serves both the cooldown gap and the watchdog, sized for the larger limit.
   localparam int CNT_MAX = (timeoutCycles > cooldownCycles) ? timeoutCycles : cooldownCycles;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT     = 2'd1,
      COOLDOWN = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic                last_served_q, last_served_d;
   logic                enabled_q, enabled_d;
   logic [1:0]          grant_q, grant_d;
   logic [1:0]          done_q, done_d;
   logic [3:0]          code_q, code_d;
   logic [addrBits-1:0] channel_q, channel_d;
   logic [dataBits-1:0] data_q, data_d;
   logic [addrBits-1:0] num_words_q, num_words_d;
   logic [8:0]          jump_q, jump_d;
   logic                in_alt_q, in_alt_d;
   logic                source_q, source_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                sel;
`ifdef CORE_MSG_ARB_WATCHDOG_EN
   logic                watchdog_fired_q, watchdog_fired_d;
`endif

   always_comb begin
      state_d       = state_q;
      last_served_d = last_served_q;
      enabled_d     = enabled_q;
      grant_d       = 2'b00;
      done_d        = 2'b00;
      code_d        = code_q;
      channel_d     = channel_q;
      data_d        = data_q;
      num_words_d   = num_words_q;
      jump_d        = jump_q;
      in_alt_d      = in_alt_q;
      source_d      = source_q;
      cnt_d         = cnt_q;
      sel           = 1'b0;
`ifdef CORE_MSG_ARB_WATCHDOG_EN
      watchdog_fired_d = watchdog_fired_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.core0Request || bus.core1Request) begin
               // On a tie the core that was not served last wins.
               sel = (bus.core0Request && bus.core1Request) ? ~last_served_q : bus.core1Request;
               if (sel) begin
                  code_d      = bus.core1Message;
                  channel_d   = bus.core1Channel;
                  data_d      = bus.core1Data;
                  num_words_d = bus.core1NumWords;
                  jump_d      = bus.core1JumpDestination;
                  in_alt_d    = bus.core1InAlt;
               end else begin
                  code_d      = bus.core0Message;
                  channel_d   = bus.core0Channel;
                  data_d      = bus.core0Data;
                  num_words_d = bus.core0NumWords;
                  jump_d      = bus.core0JumpDestination;
                  in_alt_d    = bus.core0InAlt;
               end
               source_d       = sel;
               last_served_d  = sel;
               enabled_d      = 1'b1;
               grant_d[sel]   = 1'b1;
               state_d        = WAIT;
`ifdef CORE_MSG_ARB_WATCHDOG_EN
               cnt_d          = CNT_W'(timeoutCycles);
`endif
            end
         end
         WAIT: begin
            if (bus.finished) begin
               enabled_d        = 1'b0;
               done_d[source_q] = 1'b1;
               cnt_d            = CNT_W'(cooldownCycles);
               state_d          = COOLDOWN;
            end
`ifdef CORE_MSG_ARB_WATCHDOG_EN
            else if (cnt_q <= CNT_W'(1)) begin
               // Abandon the message silently: the owning core never sees a done pulse.
               enabled_d        = 1'b0;
               watchdog_fired_d = 1'b1;
               cnt_d            = CNT_W'(cooldownCycles);
               state_d          = COOLDOWN;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
`endif
         end
         COOLDOWN: begin
            if (cnt_q <= CNT_W'(1)) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         last_served_q <= 1'b1;
         enabled_q     <= 1'b0;
         grant_q       <= 2'b00;
         done_q        <= 2'b00;
         code_q        <= '0;
         channel_q     <= '0;
         data_q        <= '0;
         num_words_q   <= '0;
         jump_q        <= '0;
         in_alt_q      <= 1'b0;
         source_q      <= 1'b0;
         cnt_q         <= '0;
      end else begin
         state_q       <= state_d;
         last_served_q <= last_served_d;
         enabled_q     <= enabled_d;
         grant_q       <= grant_d;
         done_q        <= done_d;
         code_q        <= code_d;
         channel_q     <= channel_d;
         data_q        <= data_d;
         num_words_q   <= num_words_d;
         jump_q        <= jump_d;
         in_alt_q      <= in_alt_d;
         source_q      <= source_d;
         cnt_q         <= cnt_d;
      end
   end

`ifdef CORE_MSG_ARB_WATCHDOG_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         watchdog_fired_q <= 1'b0;
      end else begin
         watchdog_fired_q <= watchdog_fired_d;
      end
   end
   assign bus.watchdogFired = watchdog_fired_q;
`else
   assign bus.watchdogFired = 1'b0;
`endif

   assign bus.core0Grant                 = grant_q[0];
   assign bus.core1Grant                 = grant_q[1];
   assign bus.core0Done                  = done_q[0];
   assign bus.core1Done                  = done_q[1];
   assign bus.enabled                    = enabled_q;
   assign bus.coreMessage                = code_q;
   assign bus.coreMessageChannel         = channel_q;
   assign bus.coreMessageMessage         = data_q;
   assign bus.coreMessageNumWords        = num_words_q;
   assign bus.coreMessageJumpDestination = jump_q;
   assign bus.coreHadMessageInAlt        = in_alt_q;
   assign bus.coreMessageSource          = source_q;
   assign bus.busy                       = (state_q != IDLE);
endmodule
